pdp8_mem_arbiter: RTL
=====================

# pdp8_mem_arbiter

Arbitrates the single-ported PDP8 main memory between the instruction-fetch/decode read port and the execute unit's read and write ports. Each transaction is sequenced through an issue/wait/done state machine with a fixed memory read latency. Priority goes to the execute unit, and a bounded-wait counter prevents fetch starvation. The block sits between `instr_decode`/the execute stage and the memory model, replacing direct point-to-point memory connections.

## Interface
- `ADDR_WIDTH`, default 12: memory address width.
- `DATA_WIDTH`, default 12: memory word width.
- `MAX_WAIT`, default 4: number of lost IDLE arbitrations after which the fetch port wins.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
  - `clk`  input  1  single clock; all state changes on its rising edge.
  - `reset`  input  1  asynchronous, active-high reset.
- `ifu_rd_req`  input  1  fetch read request; held until `ifu_rd_ack`.
- `ifu_rd_addr`  input  ADDR_WIDTH  fetch address; stable while the request is held.
- `ifu_rd_data`  output  DATA_WIDTH  fetch read data; valid with the ack and held until the next fetch ack.
- `ifu_rd_ack`  output  1  one-cycle completion pulse.
- `ifu_stall`  output  1  `ifu_rd_req & ~ifu_rd_ack` (combinational).
- `exec_rd_req`, `exec_rd_addr`, `exec_rd_data`, `exec_rd_ack`  same directions and widths as the fetch port; execute read.
- `exec_wr_req`  input  1  execute write request.
- `exec_wr_addr`  input  ADDR_WIDTH  write address.
- `exec_wr_data`  input  DATA_WIDTH  write data.
- `exec_wr_ack`  output  1  one-cycle completion pulse.
- `mem_req`  output  1  memory access strobe, one cycle per transaction.
- `mem_we`  output  1  1 = write, 0 = read; qualified by `mem_req`.
- `mem_addr`  output  ADDR_WIDTH  memory address.
- `mem_wdata`  output  DATA_WIDTH  memory write data.
- `mem_rdata`  input  DATA_WIDTH  read data; valid exactly one cycle after a read `mem_req`.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT, DONE.
- IDLE:
  - Samples the requests.
  - If any request is high, latches the winner (`gnt`: IFU, EXR or EXW), its address and its write data, then goes to ISSUE.
  - Otherwise stays in IDLE.
- Winner selection:
  - If `wait_cnt == MAX_WAIT` and `ifu_rd_req` is high, IFU wins.
  - Otherwise the fixed priority is `exec_wr` > `exec_rd` > `ifu_rd`.
- ISSUE:
  - `mem_req = 1`.
  - `mem_we = 1` for EXW, else 0.
  - `mem_addr` and `mem_wdata` come from the latched values.
  - Next state is DONE for a write, RD_WAIT for a read.
- RD_WAIT: captures `mem_rdata` into the winning port's data register, then goes to DONE.
- DONE: pulses the winning port's ack, then goes to IDLE.
- Requester protocol:
  - A requester drops its request in the cycle after it sees the ack.
  - The arbiter therefore never re-grants the same completed request.
- Starvation counter `wait_cnt`:
  - Increments, saturating at `MAX_WAIT`, on each IDLE grant to an exec port while `ifu_rd_req` is high.
  - Clears to 0 on each IFU grant.
- A request dropped before its ack is a protocol violation. The transaction still completes and the ack still pulses.
- Transactions are fully serialized, so no read/write address hazard exists.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; `wait_cnt` = 0; `gnt` cleared.
  - `mem_req`, `mem_we` and all acks = 0.
  - `mem_addr`, `mem_wdata`, `ifu_rd_data` and `exec_rd_data` = 0.
  - An in-flight read is discarded, with no ack after reset release.
- Read: request sampled in IDLE at cycle N; `mem_req` at N+1; data captured at N+2; ack and data valid at N+3; IDLE at N+4.
  - Request-to-ack latency is 3 cycles.
- Write: request sampled at N; `mem_req`/`mem_we` at N+1; ack at N+2; IDLE at N+3.
  - Request-to-ack latency is 2 cycles.
- Throughput, back-to-back: one read per 4 cycles, one write per 3 cycles.
- Simultaneous requests are resolved only in IDLE. Requests that arrive mid-transaction wait for the next IDLE.
- `mem_req` is never high for two consecutive cycles.
- Outputs are registered, except `ifu_stall`.

## Test plan
- Reset held for 5 cycles with `exec_wr_req` high -> `mem_req` = 0 and all acks = 0 throughout. After release, the first `mem_req` is one cycle after the first IDLE sample.
- Lone fetch, `ifu_rd_addr` = 12'o0200, memory word 12'o7402 -> `mem_req` at N+1 with `mem_addr` = 12'o0200; `ifu_rd_ack` at N+3 with `ifu_rd_data` = 12'o7402. `ifu_stall` is high from N to N+2.
- Write followed by read of 12'o0050 with data 12'o1234 -> `exec_wr_ack` at N+2; the subsequent `exec_rd_data` = 12'o1234.
- `ifu_rd_req`, `exec_rd_req` and `exec_wr_req` all raised in the same cycle -> service order is EXW, EXR, IFU. Each ack is a single cycle.
- `exec_rd_req` held continuously with `ifu_rd_req` high -> after 4 exec grants (`MAX_WAIT` = 4) IFU is granted, and `wait_cnt` returns to 0.
- `reset` asserted in RD_WAIT -> no `exec_rd_ack` is issued and `exec_rd_data` = 0. After release, the held request is re-serviced correctly.

Source files
------------

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: shares the single-ported PDP8 main memory between the
// fetch read port and the execute read/write ports. One transaction at a
// time runs through IDLE -> ISSUE -> (RD_WAIT) -> DONE. The execute unit has
// priority; a saturating counter forces a fetch grant after MAX_WAIT losses.
module pdp8_mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // fetch read port
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  output logic                  ifu_stall,
  // execute read port
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_ack,
  // execute write port
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  // memory side
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RD_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IFU  = 2'd1,
    G_EXR  = 2'd2,
    G_EXW  = 2'd3
  } gnt_t;

  state_t            state_reg, state_next;
  gnt_t              gnt_reg, gnt_next;
  gnt_t              win;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;

  logic                  mem_req_next, mem_we_next;
  logic                  ifu_ack_next, exr_ack_next, exw_ack_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next;
  logic [DATA_WIDTH-1:0] ifu_data_next, exr_data_next;

  // Stall the fetch port for as long as its request is outstanding.
  assign ifu_stall = ifu_rd_req & ~ifu_rd_ack;

  // Winner of an IDLE arbitration: starving fetch first, then EXW > EXR > IFU.
  always_comb begin
    win = G_NONE;
    if (ifu_rd_req && (wait_cnt_reg == CNT_MAX)) win = G_IFU;
    else if (exec_wr_req)                        win = G_EXW;
    else if (exec_rd_req)                        win = G_EXR;
    else if (ifu_rd_req)                         win = G_IFU;
  end

  // State, grant and starvation counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      gnt_reg      <= G_NONE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic; the grant is only re-decided in IDLE.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        gnt_next = win;
        if (win != G_NONE) state_next = S_ISSUE;
      end
      S_ISSUE:   state_next = (gnt_reg == G_EXW) ? S_DONE : S_RD_WAIT;
      S_RD_WAIT: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned with the state they belong to.
  always_comb begin
    mem_req_next   = (state_next == S_ISSUE);
    mem_we_next    = (state_next == S_ISSUE) && (gnt_next == G_EXW);
    ifu_ack_next   = (state_next == S_DONE) && (gnt_next == G_IFU);
    exr_ack_next   = (state_next == S_DONE) && (gnt_next == G_EXR);
    exw_ack_next   = (state_next == S_DONE) && (gnt_next == G_EXW);
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    ifu_data_next  = ifu_rd_data;
    exr_data_next  = exec_rd_data;
    wait_cnt_next  = wait_cnt_reg;

    // The memory address/data registers double as the latched request.
    if (state_reg == S_IDLE) begin
      unique case (win)
        G_IFU: begin
          mem_addr_next = ifu_rd_addr;
          wait_cnt_next = '0;
        end
        G_EXR: begin
          mem_addr_next = exec_rd_addr;
          if (ifu_rd_req && (wait_cnt_reg != CNT_MAX))
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
        G_EXW: begin
          mem_addr_next  = exec_wr_addr;
          mem_wdata_next = exec_wr_data;
          if (ifu_rd_req && (wait_cnt_reg != CNT_MAX))
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end

    // Read data arrives the cycle after the strobe, i.e. while in RD_WAIT.
    if (state_reg == S_RD_WAIT) begin
      if (gnt_reg == G_IFU) ifu_data_next = mem_rdata;
      if (gnt_reg == G_EXR) exr_data_next = mem_rdata;
    end
  end

  // Output registers; reset discards any in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ifu_rd_ack   <= 1'b0;
      exec_rd_ack  <= 1'b0;
      exec_wr_ack  <= 1'b0;
      ifu_rd_data  <= '0;
      exec_rd_data <= '0;
    end else begin
      mem_req      <= mem_req_next;
      mem_we       <= mem_we_next;
      mem_addr     <= mem_addr_next;
      mem_wdata    <= mem_wdata_next;
      ifu_rd_ack   <= ifu_ack_next;
      exec_rd_ack  <= exr_ack_next;
      exec_wr_ack  <= exw_ack_next;
      ifu_rd_data  <= ifu_data_next;
      exec_rd_data <= exr_data_next;
    end
  end

endmodule
